// File: rtl/seg_scan_if.sv
// Write port and display outputs of the scan controller.
// Master drives frame writes; slave (the controller) drives decoder and selects.
interface seg_scan_if #(
    parameter int NDIG = 8
);
    logic                wr_en;
    logic [4*NDIG-1:0]   wr_data;
    logic [NDIG-1:0]     wr_mask;
    logic                wr_ready;
    logic [3:0]          dec_data;
    logic [NDIG-1:0]     dig_sel;
    logic                frame_done;

    modport master (
        output wr_en,
        output wr_data,
        output wr_mask,
        input  wr_ready,
        input  dec_data,
        input  dig_sel,
        input  frame_done
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  wr_mask,
        output wr_ready,
        output dec_data,
        output dig_sel,
        output frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller with a double-buffered frame and a dark guard per slot.
// Latency: a write is first visible in digit 0 SHOW of the frame after its commit.
// Backpressure: wr_ready low while a shadow frame waits; writes seen then are dropped.
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [NDIG-1:0][3:0] act_data;
    logic [NDIG-1:0][3:0] sh_data;
    logic [NDIG-1:0]      act_mask;
    logic [NDIG-1:0]      sh_mask;
    logic                 pending;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cnt;

    logic                 slot_end;
    logic                 frame_end;
    logic                 show;
    logic                 accept;
    logic [3:0]           dec_q;
    logic [NDIG-1:0]      sel_q;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign show      = (cnt >= CNT_BLANK);
    assign accept    = bus.wr_en && !pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            act_data <= '0;
            act_mask <= '0;
            sh_data  <= '0;
            sh_mask  <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // accept requires !pending, so it can never collide with a commit
            if (frame_end && pending) begin
                act_data <= sh_data;
                act_mask <= sh_mask;
                pending  <= 1'b0;
            end else if (accept) begin
                sh_data  <= bus.wr_data;
                sh_mask  <= bus.wr_mask;
                pending  <= 1'b1;
            end
        end
    end

    // Outputs depend only on registered state; no input reaches them combinationally.
    always_comb begin
        dec_q = 4'h0;
        sel_q = '1;
        if (show) begin
            dec_q      = act_data[idx];
            sel_q[idx] = ~act_mask[idx];
        end
    end

    assign bus.dec_data   = dec_q;
    assign bus.dig_sel    = sel_q;
    assign bus.frame_done = frame_end;
    assign bus.wr_ready   = ~pending;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scenarios plus random traffic checked against a time-indexed frame model.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic clk;
    logic rst;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int lit_cnt = 0;
    int fd_cnt  = 0;

    // Model: displayed frame, shadow frame, pending flag; time is cyc since reset.
    logic [15:0] m_data = '0;
    logic [3:0]  m_mask = '0;
    logic [15:0] m_sh   = '0;
    logic [3:0]  m_shm  = '0;
    logic        m_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic en, input logic [15:0] d, input logic [3:0] m, input logic r);
        int ph;
        int dg;
        logic [3:0] e_sel;
        logic [3:0] e_dec;
        logic pend_before;
        @(negedge clk);
        rst         = r;
        bus.wr_en   = en;
        bus.wr_data = d;
        bus.wr_mask = m;

        ph    = cyc % DIV;
        dg    = (cyc % FRAME) / DIV;
        e_sel = 4'hF;
        e_dec = 4'h0;
        if (ph >= BLANK) begin
            e_dec = m_data[dg*4 +: 4];
            if (m_mask[dg]) e_sel[dg] = 1'b0;
        end
        chk("dig_sel",    32'(bus.dig_sel),    32'(e_sel));
        chk("dec_data",   32'(bus.dec_data),   32'(e_dec));
        chk("frame_done", 32'(bus.frame_done), 32'((cyc % FRAME) == FRAME - 1));
        chk("wr_ready",   32'(bus.wr_ready),   32'(!m_pend));
        if (bus.dig_sel !== 4'hF) lit_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;

        if (r) begin
            m_data = '0; m_mask = '0; m_sh = '0; m_shm = '0; m_pend = 1'b0;
            cyc    = 0;
        end else begin
            pend_before = m_pend;
            if ((cyc % FRAME) == FRAME - 1 && pend_before) begin
                m_data = m_sh;
                m_mask = m_shm;
                m_pend = 1'b0;
            end
            if (en && !pend_before) begin
                m_sh   = d;
                m_shm  = m;
                m_pend = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic reset_dut();
        step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b0, 16'h0, 4'h0, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.wr_mask = '0;
        @(posedge clk);
        reset_dut();

        // Idle: dark display, frame_done only at frame ends
        lit_cnt = 0;
        fd_cnt  = 0;
        for (int c = 0; c < 64; c++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            if (c == 31 || c == 63) chk("idle_fd_edge", 32'(bus.frame_done), 32'd1);
        end
        chk("idle_lit", 32'(lit_cnt), 32'd0);
        chk("idle_fd_count", 32'(fd_cnt), 32'd2);
        chk("idle_ready", 32'(bus.wr_ready), 32'd1);

        // Single write at 5, dropped write at 10
        reset_dut();
        for (int c = 0; c < 56; c++) begin
            step(c == 5 || c == 10, (c == 10) ? 16'hFFFF : 16'h4321, 4'hF, 1'b0);
            if (c == 6)  chk("sw_ready6",  32'(bus.wr_ready), 32'd0);
            if (c == 31) chk("sw_ready31", 32'(bus.wr_ready), 32'd0);
            if (c == 32) chk("sw_ready32", 32'(bus.wr_ready), 32'd1);
            if (c == 34 || c == 39) begin
                chk("sw_sel_d0", 32'(bus.dig_sel), 32'hE);
                chk("sw_dec_d0", 32'(bus.dec_data), 32'h1);
            end
            if (c == 40 || c == 41) chk("sw_guard", 32'(bus.dig_sel), 32'hF);
            if (c == 42 || c == 47) begin
                chk("sw_sel_d1", 32'(bus.dig_sel), 32'hD);
                chk("sw_dec_d1", 32'(bus.dec_data), 32'h2);
            end
            if (c == 51) chk("sw_dec_d2", 32'(bus.dec_data), 32'h3);
        end

        // Mask 0101: digits 1 and 3 dark, timing unchanged
        reset_dut();
        for (int c = 0; c < 64; c++) begin
            step(c == 0, 16'hABCD, 4'b0101, 1'b0);
            if (c == 35) begin
                chk("mask_sel_d0", 32'(bus.dig_sel), 32'hE);
                chk("mask_dec_d0", 32'(bus.dec_data), 32'hD);
            end
            if (c == 43) chk("mask_sel_d1", 32'(bus.dig_sel), 32'hF);
            if (c == 51) begin
                chk("mask_sel_d2", 32'(bus.dig_sel), 32'hB);
                chk("mask_dec_d2", 32'(bus.dec_data), 32'hB);
            end
            if (c == 59) chk("mask_sel_d3", 32'(bus.dig_sel), 32'hF);
            if (c == 63) chk("mask_fd63", 32'(bus.frame_done), 32'd1);
        end

        // Boundary collision: wr_en held across the commit cycle
        reset_dut();
        for (int c = 0; c < 72; c++) begin
            step(c == 0 || (c >= 28 && c <= 32),
                 (c == 0) ? 16'h1111 : ((c == 32) ? 16'h5555 : 16'h9999), 4'hF, 1'b0);
            if (c == 31) chk("bc_ready31", 32'(bus.wr_ready), 32'd0);
            if (c == 32) chk("bc_ready32", 32'(bus.wr_ready), 32'd1);
            if (c == 33) chk("bc_ready33", 32'(bus.wr_ready), 32'd0);
            if (c == 35) chk("bc_dec_f1", 32'(bus.dec_data), 32'h1);
            if (c == 67) chk("bc_dec_f2", 32'(bus.dec_data), 32'h5);
        end

        // Reset mid-frame with a pending shadow
        reset_dut();
        for (int c = 0; c <= 45; c++) begin
            step(c == 0 || c == 40, (c == 0) ? 16'h7777 : 16'h3333, 4'hF, c == 45);
            if (c == 44) chk("rm_ready44", 32'(bus.wr_ready), 32'd0);
            if (c == 44) chk("rm_lit44", 32'(bus.dig_sel), 32'hD);
        end
        lit_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            if (c == 0) begin
                chk("rm_sel0", 32'(bus.dig_sel), 32'hF);
                chk("rm_ready0", 32'(bus.wr_ready), 32'd1);
            end
        end
        chk("rm_dark", 32'(lit_cnt), 32'd0);

        // Random traffic against the model
        reset_dut();
        repeat (400) begin
            step($urandom_range(0, 7) == 0, 16'($urandom()), 4'($urandom()),
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
